// File: rtl/hpc3_rnd_feeder_if.sv
// ---------------------------------------------------------------------------
// hpc3_rnd_feeder_if
// Purpose : bundles the two valid/ready channels of the randomness feeder.
//           The PRNG word channel comes in, and the gadget bundle channel
//           goes out.
// Signals :
//   in_valid   PRNG word valid                 (master -> slave)
//   in_ready   feeder can take a word          (slave  -> master)
//   in_data    PRNG word, IN_W bits            (master -> slave)
//   out_valid  a full bundle is available      (slave  -> master)
//   out_ready  gadget bank consumes the bundle (master -> slave)
//   out_rnd    randomness bundle, RND_W bits   (slave  -> master)
// Modports: master = PRNG / gadget-bank side, slave = the feeder itself.
// ---------------------------------------------------------------------------
interface hpc3_rnd_feeder_if #(
    parameter int IN_W  = 32,
    parameter int RND_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [RND_W-1:0] out_rnd;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_rnd
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_rnd
    );
endinterface

// File: rtl/hpc3_rnd_feeder.sv
// ---------------------------------------------------------------------------
// hpc3_rnd_feeder
// Purpose : randomness staging buffer between a PRNG and a bank of HPC3
//           masked AND gadgets. PRNG words are packed into a bit buffer, and
//           one fresh RND_W-bit bundle is handed out per output transfer.
//           Every bit is delivered exactly once. On starvation out_valid
//           simply stays low; no substitute randomness is ever produced.
// Ports   :
//   i_clk         clock, all state on rising edge
//   i_rst_n       synchronous reset, active low
//   bus           hpc3_rnd_feeder_if.slave (PRNG in, bundle out)
//   o_starve_cnt  16-bit saturating starvation counter, present only when
//                 HPC3_RND_FEEDER_STATS_EN is defined
// Config  : HPC3_RND_FEEDER_STATS_EN enables the starvation counter.
// ---------------------------------------------------------------------------
module hpc3_rnd_feeder #(
    parameter int d         = 2,
    parameter int N_GADGETS = 8,
    parameter int IN_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    hpc3_rnd_feeder_if.slave bus
`ifdef HPC3_RND_FEEDER_STATS_EN
    ,
    output logic [15:0]      o_starve_cnt
`endif
);
    localparam int RND_W = N_GADGETS * d * (d - 1);
    localparam int CAP   = RND_W + IN_W;
    localparam int CW    = $clog2(CAP + 1);

    localparam logic [CW-1:0] C_RND_W = CW'(RND_W);
    localparam logic [CW-1:0] C_IN_W  = CW'(IN_W);

    logic [CAP-1:0] r_buf;
    logic [CW-1:0]  r_fill;

    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_in_fire;
    logic           w_out_fire;
    logic [CAP-1:0] w_shifted;
    logic [CAP-1:0] w_ins_data;
    logic [CAP-1:0] w_ins_mask;
    logic [CAP-1:0] w_buf_next;
    logic [CW-1:0]  w_wr_base;
    logic [CW-1:0]  w_fill_next;

    // Handshake flags come from registered fill only; in_ready accepts a word
    // only when it is guaranteed to fit (fill+IN_W <= CAP), so no overflow.
    always_comb begin
        w_in_ready  = i_rst_n & (r_fill <= C_RND_W);
        w_out_valid = (r_fill >= C_RND_W);
        w_in_fire   = bus.in_valid & w_in_ready;
        w_out_fire  = w_out_valid & bus.out_ready;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_rnd   = r_buf[RND_W-1:0];

    // Next buffer: consume first (zero-filling shift), then insert the new
    // word right above the surviving valid bits. A mask-and-or insert keeps
    // the write position fully variable without a part-select range issue.
    always_comb begin
        w_shifted   = r_buf;
        w_wr_base   = r_fill;
        w_fill_next = r_fill;
        if (w_out_fire) begin
            w_shifted = r_buf >> RND_W;
            w_wr_base = r_fill - C_RND_W;
        end
        w_ins_data = {{RND_W{1'b0}}, bus.in_data} << w_wr_base;
        w_ins_mask = {{RND_W{1'b0}}, {IN_W{1'b1}}} << w_wr_base;
        w_buf_next = w_shifted;
        if (w_in_fire) begin
            w_buf_next = (w_shifted & ~w_ins_mask) | w_ins_data;
        end
        if (w_in_fire) begin
            w_fill_next = w_fill_next + C_IN_W;
        end
        if (w_out_fire) begin
            w_fill_next = w_fill_next - C_RND_W;
        end
    end

    // Reset wipes the buffer so pre-reset randomness can never resurface.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_next;
            r_fill <= w_fill_next;
        end
    end

`ifdef HPC3_RND_FEEDER_STATS_EN
    logic [15:0] r_starve_cnt;

    // Counts cycles where the gadget bank wanted randomness but none was
    // ready; saturates rather than wrapping so long stalls stay visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (bus.out_ready && !w_out_valid && (r_starve_cnt != 16'hFFFF)) begin
            r_starve_cnt <= r_starve_cnt + 16'd1;
        end
    end

    assign o_starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_hpc3_rnd_feeder.sv
module tb_hpc3_rnd_feeder;

   logic clk = 1'b0;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   logic [15:0] qMain[$];
   logic [5:0]  qOdd[$];
   logic [15:0] expMain;
   logic [5:0]  expOdd;

   hpc3_rnd_feeder_if #(.IN_W(32), .RND_W(16)) busMain ();
   hpc3_rnd_feeder_if #(.IN_W(4),  .RND_W(6))  busOdd ();

`ifdef HPC3_RND_FEEDER_STATS_EN
   logic [15:0] starveMain;
   logic [15:0] starveOdd;
`endif

   // Free-running clock for both instances.
   always #5 clk = ~clk;

   hpc3_rnd_feeder #(.d(2), .N_GADGETS(8), .IN_W(32)) dutMain (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (busMain)
`ifdef HPC3_RND_FEEDER_STATS_EN
      ,
      .o_starve_cnt (starveMain)
`endif
   );

   hpc3_rnd_feeder #(.d(3), .N_GADGETS(1), .IN_W(4)) dutOdd (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (busOdd)
`ifdef HPC3_RND_FEEDER_STATS_EN
      ,
      .o_starve_cnt (starveOdd)
`endif
   );

   // Scoreboard monitor for the default-geometry instance: every bundle the
   // DUT hands over must be the next expected one in the queue.
   always @(negedge clk) begin
      if (rst_n && busMain.out_valid && busMain.out_ready) begin
         checks++;
         if (qMain.size() == 0) begin
            errors++;
            $display("[TB] FAIL mainBundle: got=%h expected=none (unexpected output)", busMain.out_rnd);
         end else begin
            expMain = qMain.pop_front();
            if (busMain.out_rnd !== expMain) begin
               errors++;
               $display("[TB] FAIL mainBundle: got=%h expected=%h", busMain.out_rnd, expMain);
            end
         end
      end
   end

   // Scoreboard monitor for the odd-geometry instance.
   always @(negedge clk) begin
      if (rst_n && busOdd.out_valid && busOdd.out_ready) begin
         checks++;
         if (qOdd.size() == 0) begin
            errors++;
            $display("[TB] FAIL oddBundle: got=%b expected=none (unexpected output)", busOdd.out_rnd);
         end else begin
            expOdd = qOdd.pop_front();
            if (busOdd.out_rnd !== expOdd) begin
               errors++;
               $display("[TB] FAIL oddBundle: got=%b expected=%b", busOdd.out_rnd, expOdd);
            end
         end
      end
   end

   // Drive the default instance for one clock, inputs changed after the edge.
   task automatic applyStimulus(input logic v, input logic [31:0] data, input logic r);
      busMain.in_valid  = v;
      busMain.in_data   = data;
      busMain.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
      end
   endtask

   // Offer one nibble to the odd instance and wait (bounded) for acceptance.
   task automatic sendOdd(input logic [3:0] nib);
      logic got;
      got = 1'b0;
      busOdd.in_valid = 1'b1;
      busOdd.in_data  = nib;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (busOdd.in_ready) got = 1'b1;
      end
      @(posedge clk);
      #1;
      busOdd.in_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL oddAccept: got=timeout expected=in_ready within 20 cycles");
      end
   endtask

   initial begin
      rst_n             = 1'b0;
      busMain.in_valid  = 1'b0;
      busMain.in_data   = '0;
      busMain.out_ready = 1'b0;
      busOdd.in_valid   = 1'b0;
      busOdd.in_data    = '0;
      busOdd.out_ready  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetOutValid", 32'(busMain.out_valid), 32'd0);
      checkOutput("resetInReady",  32'(busMain.in_ready),  32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("releaseInReady",  32'(busMain.in_ready),  32'd1);
      checkOutput("releaseOutValid", 32'(busMain.out_valid), 32'd0);

      // Basic flow: one word gives two bundles, LSB half first
      qMain.push_back(16'hBEEF);
      qMain.push_back(16'hDEAD);
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
      checkOutput("basicOutValid", 32'(busMain.out_valid), 32'd1);
      checkOutput("basicInReady",  32'(busMain.in_ready),  32'd0);
      checkOutput("basicFirstRnd", 32'(busMain.out_rnd),   32'h0000BEEF);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("basicDrained", 32'(busMain.out_valid), 32'd0);

      // Simultaneous in/out transfers with one bundle pending
      qMain.push_back(16'hBEEF);
      qMain.push_back(16'hDEAD);
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("simPendingInReady", 32'(busMain.in_ready), 32'd1);
      qMain.push_back(16'h5678);
      qMain.push_back(16'h1234);
      applyStimulus(1'b1, 32'h12345678, 1'b1);
      checkOutput("simFill32InReady", 32'(busMain.in_ready),  32'd0);
      checkOutput("simFill32Valid",   32'(busMain.out_valid), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("simDrained", 32'(busMain.out_valid), 32'd0);

      // Backpressure: bundle must hold still while out_ready is low
      qMain.push_back(16'h2222);
      qMain.push_back(16'h1111);
      applyStimulus(1'b1, 32'h11112222, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         checkOutput("bpOutValid", 32'(busMain.out_valid), 32'd1);
         checkOutput("bpOutRnd",   32'(busMain.out_rnd),   32'h00002222);
         checkOutput("bpInReady",  32'(busMain.in_ready),  32'd0);
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("bpDrained", 32'(busMain.out_valid), 32'd0);

      // Reset mid-run: buffered data must be discarded, never expected
      applyStimulus(1'b1, 32'hAAAA5555, 1'b0);
      busMain.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midResetInReady", 32'(busMain.in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("midResetOutValid", 32'(busMain.out_valid), 32'd0);
      checkOutput("midResetInReady2", 32'(busMain.in_ready),  32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("postResetInReady", 32'(busMain.in_ready), 32'd1);
      qMain.push_back(16'hF00D);
      qMain.push_back(16'hCAFE);
      applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("postResetDrained", 32'(busMain.out_valid), 32'd0);
      busMain.out_ready = 1'b0;

      // Odd geometry: 4-bit words into 6-bit bundles, leftovers carry over
      busOdd.out_ready = 1'b1;
      qOdd.push_back(6'b100001);
      qOdd.push_back(6'b001100);
      qOdd.push_back(6'b011111);
      sendOdd(4'h1);
      sendOdd(4'h2);
      sendOdd(4'h3);
      sendOdd(4'hF);
      sendOdd(4'h5);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("oddLeftoverHeld", 32'(busOdd.out_valid), 32'd0);
      checkOutput("mainQueueEmpty", 32'(qMain.size()), 32'd0);
      checkOutput("oddQueueEmpty",  32'(qOdd.size()),  32'd0);

`ifdef HPC3_RND_FEEDER_STATS_EN
      // Starvation counter: counts and then saturates
      busOdd.out_ready = 1'b0;
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("starveFive", 32'(starveMain), 32'd5);
      repeat (70000) @(posedge clk);
      #1;
      checkOutput("starveSaturate", 32'(starveMain), 32'h0000FFFF);
      busMain.out_ready = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
